// File: rtl/sound_pkg.sv
// Shared definitions for the game sound link (generator and decoder):
// tone codes, nominal half-periods, decoder FSM states and the
// half-period classifier.
package sound_pkg;

  // 2-bit tone codes carried over the link
  localparam logic [1:0] SND_GO   = 2'b11;
  localparam logic [1:0] SND_PING = 2'b10;
  localparam logic [1:0] SND_PONG = 2'b01;
  localparam logic [1:0] SND_STOP = 2'b00;

  // Nominal half-periods in clk cycles (generator setting f -> 2^(f+1))
  localparam int unsigned NOM_GO      = 8192;
  localparam int unsigned NOM_PING    = 16384;
  localparam int unsigned NOM_PONG    = 32768;
  localparam int unsigned NOM_STOP    = 65536;
  localparam int unsigned NOM_GO_LOG2 = 13;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    LOCKED
  } sound_state_t;

  typedef struct packed {
    logic       good;
    logic [1:0] code;
  } sound_class_t;

  // Window for nominal N is [3N/4, 3N/2); windows are contiguous and
  // built from shifts only. go_log2 is log2 of the shortest (go) nominal.
  function automatic sound_class_t classify(input logic [31:0] h,
                                            input int unsigned go_log2);
    sound_class_t r;
    logic [31:0]  n;
    r.good = 1'b0;
    r.code = SND_STOP;
    for (int k = 0; k < 4; k++) begin
      n = 32'd1 << (go_log2 + k);
      if ((h >= ((n >> 1) + (n >> 2))) && (h < (n + (n >> 1)))) begin
        r.good = 1'b1;
        r.code = 2'(3 - k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sound_edge_sync.sv
// Input conditioning for the sound pin: 2-FF synchronizer, optional
// 3-sample stability filter, and a registered pulse on either polarity.
// Optional feature macro: SOUND_DECODER_DEGLITCH_EN (filter enabled,
// edge latency 5 cycles); default build has 3-cycle edge latency.
module sound_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic sound_in,
  output logic edge_det
);

  logic sync1_reg;
  logic sync2_reg;
  logic lvl_reg;
  logic lvl_next;
  logic edge_reg;

`ifdef SOUND_DECODER_DEGLITCH_EN
  logic [1:0] hist_reg;

  // Two-deep history of the synchronized level for the stability check
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_reg <= 2'b00;
    end else begin
      hist_reg <= {hist_reg[0], sync2_reg};
    end
  end

  // Filtered level follows the pin only after 3 equal consecutive samples
  always_comb begin
    lvl_next = lvl_reg;
    if ((sync2_reg == hist_reg[0]) && (hist_reg[0] == hist_reg[1])) begin
      lvl_next = sync2_reg;
    end
  end
`else
  // No filter: every synchronized transition counts
  always_comb begin
    lvl_next = sync2_reg;
  end
`endif

  // Synchronizer, level history and both-polarity edge pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      lvl_reg   <= 1'b0;
      edge_reg  <= 1'b0;
    end else begin
      sync1_reg <= sound_in;
      sync2_reg <= sync1_reg;
      lvl_reg   <= lvl_next;
      edge_reg  <= lvl_next ^ lvl_reg;
    end
  end

  assign edge_det = edge_reg;

endmodule

// File: rtl/sound_decoder.sv
// Receive end of the game sound link: measures the tone half-period,
// classifies it and reports a locked 2-bit sound code.
// Optional feature macro: SOUND_DECODER_DEGLITCH_EN (input glitch filter,
// handled inside sound_edge_sync).
module sound_decoder
  import sound_pkg::*;
#(
  parameter int unsigned MATCH_N = 4,
  parameter int unsigned TIMEOUT = 131072,
  parameter int unsigned CNT_W   = 18,
  parameter int unsigned GO_LOG2 = NOM_GO_LOG2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sound_in,
  output logic [1:0] code_sound,
  output logic       valid,
  output logic       code_stb,
  output logic       bad_period
);

  localparam int unsigned      MW        = $clog2(MATCH_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [MW-1:0]    MATCH_C   = MW'(MATCH_N);

  logic             edge_det;
  logic [CNT_W-1:0] cnt_reg;
  logic             first_reg;
  logic             timeout;
  sound_class_t     cls;
  logic [MW-1:0]    match_inc;

  sound_state_t     state_reg, state_next;
  logic [MW-1:0]    match_reg, match_next;
  logic [1:0]       cand_reg, cand_next;
  logic [1:0]       code_reg, code_next;
  logic             valid_reg, valid_next;
  logic             stb_reg, stb_next;
  logic             bad_reg, bad_next;

  sound_edge_sync u_edge (
    .clk      (clk),
    .rst      (rst),
    .sound_in (sound_in),
    .edge_det (edge_det)
  );

  // Half-period counter: restarts at 1 on each edge, saturates otherwise.
  // The first edge after reset only arms the measurement.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      first_reg <= 1'b1;
    end else if (edge_det) begin
      cnt_reg   <= CNT_W'(1);
      first_reg <= 1'b0;
    end else if (cnt_reg != CNT_MAX) begin
      cnt_reg   <= cnt_reg + CNT_W'(1);
    end
  end

  // Classifier on the value captured at the edge
  always_comb begin
    cls = classify(32'(cnt_reg), GO_LOG2);
  end

  assign timeout   = (cnt_reg == TIMEOUT_C);
  assign match_inc = match_reg + MW'(1);

  // Lock FSM: next state, candidate tracking and output updates.
  // An edge in the same cycle as the timeout takes precedence.
  always_comb begin
    state_next = state_reg;
    match_next = match_reg;
    cand_next  = cand_reg;
    code_next  = code_reg;
    valid_next = valid_reg;
    stb_next   = 1'b0;
    bad_next   = 1'b0;
    if (edge_det) begin
      if (!first_reg) begin
        if (!cls.good) begin
          bad_next   = 1'b1;
          match_next = '0;
          if (state_reg == TRACK) begin
            state_next = IDLE;
          end
        end else begin
          case (state_reg)
            IDLE: begin
              state_next = TRACK;
              cand_next  = cls.code;
              match_next = MW'(1);
            end
            TRACK: begin
              if (cls.code == cand_reg) begin
                if (match_inc == MATCH_C) begin
                  state_next = LOCKED;
                  code_next  = cand_reg;
                  valid_next = 1'b1;
                  stb_next   = 1'b1;
                  match_next = '0;
                end else begin
                  match_next = match_inc;
                end
              end else begin
                cand_next  = cls.code;
                match_next = MW'(1);
              end
            end
            LOCKED: begin
              if (cls.code == code_reg) begin
                // Current tone confirmed; any pending change is abandoned
                match_next = '0;
              end else if ((match_reg != '0) && (cls.code == cand_reg)) begin
                if (match_inc == MATCH_C) begin
                  code_next  = cand_reg;
                  stb_next   = 1'b1;
                  match_next = '0;
                end else begin
                  match_next = match_inc;
                end
              end else begin
                cand_next  = cls.code;
                match_next = MW'(1);
              end
            end
            default: begin
              state_next = IDLE;
            end
          endcase
        end
      end
    end else if (timeout) begin
      state_next = IDLE;
      valid_next = 1'b0;
      match_next = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      match_reg <= '0;
      cand_reg  <= SND_STOP;
      code_reg  <= SND_STOP;
      valid_reg <= 1'b0;
      stb_reg   <= 1'b0;
      bad_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      match_reg <= match_next;
      cand_reg  <= cand_next;
      code_reg  <= code_next;
      valid_reg <= valid_next;
      stb_reg   <= stb_next;
      bad_reg   <= bad_next;
    end
  end

  assign code_sound = code_reg;
  assign valid      = valid_reg;
  assign code_stb   = stb_reg;
  assign bad_period = bad_reg;

endmodule
